pixel_fetch_responder: RTL

PIXEL_FETCH_RESPONDER -- requirements
Module: pixel_fetch_responder

---
 rtl/superga_pkg.sv | 16 +
 rtl/rsp_fifo.sv | 55 +++++
 rtl/pixel_fetch_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/superga_pkg.sv
// Shared widths, latency limits and arbiter state type for the pixel fetch path.
package superga_pkg;

    localparam int unsigned COORD_W     = 8;
    localparam int unsigned PIX_W       = 8;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 3;
    localparam int unsigned FAIR_GRANTS = 8;

    typedef enum logic [0:0] {
        RD_PRI,
        WR_FORCE
    } arb_state_e;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO holding returned pixel bytes; head is presented combinationally.
module rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Zero head while empty so the output is clean during and after reset.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fetch_responder.sv
// Arbitrates renderer reads and host writes onto one sync SRAM port and returns
// read bytes in order through a credit-limited response FIFO.
module pixel_fetch_responder
    import superga_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [PIX_W-1:0]   rsp_byte,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [PIX_W-1:0]   wr_byte,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIX_W-1:0]   mem_wdata,
    input  logic [PIX_W-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

    arb_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               run_q;
    logic [MEM_LAT-1:0] pipe_q, pipe_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [PIX_W-1:0]   wdata_q;
    logic [1:0]         inflight;
    logic [4:0]         credits;
    logic               credit_ok;
    logic               rd_grant, wr_grant;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + {1'b0, pipe_q[i]};
        end
    end

    // Registered occupancy only: a pop frees its credit one cycle later.
    assign credits   = {3'b000, inflight} + 5'(fifo_count);
    assign credit_ok = !fifo_full && (credits < 5'(RSP_DEPTH));
    assign rd_grant  = req_valid && req_ready;
    assign wr_grant  = wr_valid && wr_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= RD_PRI;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!wr_valid || wr_grant) begin
            cnt_d = '0;
        end else if (rd_grant) begin
            cnt_d = cnt_q + 4'd1;
        end
        unique case (state_q)
            RD_PRI:   if (cnt_d == 4'(FAIR_GRANTS)) state_d = WR_FORCE;
            WR_FORCE: if (!wr_valid || wr_grant) state_d = RD_PRI;
            default:  state_d = RD_PRI;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        if (run_q) begin
            unique case (state_q)
                RD_PRI: begin
                    req_ready = credit_ok;
                    wr_ready  = !(req_valid && credit_ok);
                end
                WR_FORCE: wr_ready = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = rd_grant || wr_grant;
        mem_we    = wr_grant;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (rd_grant) begin
            mem_addr = {req_y, req_x};
        end else if (wr_grant) begin
            mem_addr  = {wr_y, wr_x};
            mem_wdata = wr_byte;
        end
    end

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = rd_grant;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            run_q   <= 1'b0;
            pipe_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            run_q   <= 1'b1;
            pipe_q  <= pipe_d;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

    rsp_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (pipe_q[MEM_LAT-1]),
        .wdata (mem_rdata),
        .pop   (rsp_valid && rsp_ready),
        .rdata (rsp_byte),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid = !fifo_empty;

endmodule
